// File: rtl/mod60_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod60_ctrl_pkg
// Description : Shared constants and FSM encoding for the mod-60 mm:ss counter
// Revision    : 1.0
// ============================================================================
package mod60_ctrl_pkg;

    localparam int MOD    = 60;
    localparam int W      = 6;
    localparam int LOAD_W = 2 * W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    // Load fields are range-checked arithmetically, independent of the
    // +1 wrap detectors in the datapath.
    function automatic logic ge_mod(input logic [W-1:0] v);
        return ({26'd0, v} >= MOD);
    endfunction

endpackage : mod60_ctrl_pkg
`default_nettype wire

// File: rtl/mod60_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mod60_ctrl_if
// Description : Control, load handshake and count outputs of mod60_ctrl
// Revision    : 1.0
// ============================================================================
interface mod60_ctrl_if;

    logic                               start;
    logic                               stop;
    logic                               clr;
    logic                               tick;
    logic                               load_valid;
    logic [mod60_ctrl_pkg::LOAD_W-1:0]  load_val;
    logic                               load_ready;
    logic                               load_err;
    logic [mod60_ctrl_pkg::W-1:0]       sec;
    logic [mod60_ctrl_pkg::W-1:0]       min;
    logic                               sec_wrap;
    logic                               hr_wrap;
    logic                               running;

    modport master (
        output start, stop, clr, tick, load_valid, load_val,
        input  load_ready, load_err, sec, min, sec_wrap, hr_wrap, running
    );

    modport slave (
        input  start, stop, clr, tick, load_valid, load_val,
        output load_ready, load_err, sec, min, sec_wrap, hr_wrap, running
    );

endinterface : mod60_ctrl_if
`default_nettype wire

// File: rtl/mod60_ctrl_range_ge60.sv
`default_nettype none
// ============================================================================
// Module      : range_ge60
// Description : Flags a 6-bit value in 60..63 (upper four bits all ones)
// Revision    : 1.0
// ============================================================================
module range_ge60 (
    input  wire logic [5:0] i,
    output logic            hit
);

    assign hit = (i[5:2] == 4'b1111);

endmodule : range_ge60
`default_nettype wire

// File: rtl/mod60_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mod60_ctrl
// Description : mm:ss counter with IDLE/RUN/PAUSE control and checked load
// Revision    : 1.0
// ============================================================================
module mod60_ctrl
    import mod60_ctrl_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   rst,
    mod60_ctrl_if.slave bus
);

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [W-1:0] r_sec;
    logic [W-1:0] r_min;
    logic         r_sec_wrap;
    logic         r_hr_wrap;
    logic         r_load_err;
    logic         r_running;

    logic [W-1:0] w_next_sec;
    logic [W-1:0] w_next_min;
    logic         w_sec_hit;
    logic         w_min_hit;
    logic         w_ready;
    logic         w_xfer;
    logic         w_load_ok;
    logic         w_count;

    assign w_next_sec = r_sec + 6'd1;
    assign w_next_min = r_min + 6'd1;

    range_ge60 u_sec_range (.i(w_next_sec), .hit(w_sec_hit));
    range_ge60 u_min_range (.i(w_next_min), .hit(w_min_hit));

    assign w_ready   = ((r_state == ST_IDLE) || (r_state == ST_PAUSE)) && !bus.clr && !rst;
    assign w_xfer    = bus.load_valid && w_ready;
    assign w_load_ok = !ge_mod(bus.load_val[LOAD_W-1:W]) && !ge_mod(bus.load_val[W-1:0]);
    // stop outranks tick, so a stop cycle in RUN does not count
    assign w_count   = (r_state == ST_RUN) && bus.tick && !bus.stop;

    // stop dominates start; in IDLE a stop simply holds IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (bus.stop) begin
            if (r_state != ST_IDLE) begin
                w_state_nxt = ST_PAUSE;
            end
        end else if (bus.start && (r_state != ST_RUN)) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r_state    <= ST_IDLE;
            r_sec      <= '0;
            r_min      <= '0;
            r_sec_wrap <= 1'b0;
            r_hr_wrap  <= 1'b0;
            r_load_err <= 1'b0;
            r_running  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_running  <= (w_state_nxt == ST_RUN);
            r_sec_wrap <= w_count && w_sec_hit;
            r_hr_wrap  <= w_count && w_sec_hit && w_min_hit;
            r_load_err <= w_xfer && !w_load_ok;
            if (w_xfer && w_load_ok) begin
                r_min <= bus.load_val[LOAD_W-1:W];
                r_sec <= bus.load_val[W-1:0];
            end else if (w_count) begin
                if (w_sec_hit) begin
                    r_sec <= '0;
                    r_min <= w_min_hit ? '0 : w_next_min;
                end else begin
                    r_sec <= w_next_sec;
                end
            end
        end
    end

    assign bus.load_ready = w_ready;
    assign bus.load_err   = r_load_err;
    assign bus.sec        = r_sec;
    assign bus.min        = r_min;
    assign bus.sec_wrap   = r_sec_wrap;
    assign bus.hr_wrap    = r_hr_wrap;
    assign bus.running    = r_running;

endmodule : mod60_ctrl
`default_nettype wire

// File: tb/tb_mod60_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod60_ctrl
// Description : Directed vector bench for mod60_ctrl
// Revision    : 1.0
// ============================================================================
module tb_mod60_ctrl;

    typedef struct {
        logic        start;
        logic        stop;
        logic        clr;
        logic        tick;
        logic        lv;
        logic [11:0] lval;
        logic [5:0]  esec;
        logic [5:0]  emin;
        logic        erun;
        logic        eswr;
        logic        ehwr;
        logic        eerr;
        logic        erdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[16];

    mod60_ctrl_if bus();

    mod60_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic sp, input logic cl, input logic tk,
                                input logic lv, input logic [11:0] lval,
                                input logic [5:0] es, input logic [5:0] em, input logic er,
                                input logic sw, input logic hw, input logic ee, input logic ey);
        vec_t v;
        v.start = st; v.stop = sp; v.clr = cl; v.tick = tk; v.lv = lv; v.lval = lval;
        v.esec = es; v.emin = em; v.erun = er; v.eswr = sw; v.ehwr = hw; v.eerr = ee; v.erdy = ey;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic sp, input logic cl, input logic tk,
                         input logic lv, input logic [11:0] lval);
        bus.start = st; bus.stop = sp; bus.clr = cl; bus.tick = tk;
        bus.load_valid = lv; bus.load_val = lval;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [5:0] es, input logic [5:0] em,
                           input logic er, input logic sw, input logic hw, input logic ee,
                           input logic ey);
        chk({tag, ".sec"},        32'(bus.sec),        32'(es));
        chk({tag, ".min"},        32'(bus.min),        32'(em));
        chk({tag, ".running"},    32'(bus.running),    32'(er));
        chk({tag, ".sec_wrap"},   32'(bus.sec_wrap),   32'(sw));
        chk({tag, ".hr_wrap"},    32'(bus.hr_wrap),    32'(hw));
        chk({tag, ".load_err"},   32'(bus.load_err),   32'(ee));
        chk({tag, ".load_ready"}, 32'(bus.load_ready), 32'(ey));
    endtask

    initial begin
        // Starting state for the table: RUN at 01:00 after the 60-tick run.
        //             st sp cl tk lv lval          sec min run sw hw err rdy
        vecs[0]  = mk(0, 0, 1, 0, 0, 12'd0,        0,  0,  0,  0, 0, 0,  0); // clr
        vecs[1]  = mk(1, 1, 0, 1, 0, 12'd0,        0,  0,  0,  0, 0, 0,  1); // start+stop in IDLE
        vecs[2]  = mk(0, 0, 0, 0, 1, 12'd3835,     59, 59, 0,  0, 0, 0,  1); // load 59:59
        vecs[3]  = mk(1, 0, 0, 0, 0, 12'd0,        59, 59, 1,  0, 0, 0,  0); // start
        vecs[4]  = mk(0, 0, 0, 1, 0, 12'd0,        0,  0,  1,  1, 1, 0,  0); // 59:59 -> 00:00
        vecs[5]  = mk(0, 0, 0, 1, 1, 12'h0C7,      1,  0,  1,  0, 0, 0,  0); // load in RUN ignored
        vecs[6]  = mk(1, 1, 0, 0, 0, 12'd0,        1,  0,  0,  0, 0, 0,  1); // start+stop in RUN
        vecs[7]  = mk(0, 0, 0, 1, 0, 12'd0,        1,  0,  0,  0, 0, 0,  1); // tick in PAUSE
        vecs[8]  = mk(0, 0, 0, 0, 1, 12'd380,      1,  0,  0,  0, 0, 1,  1); // min 5 sec 60
        vecs[9]  = mk(0, 0, 0, 0, 0, 12'd0,        1,  0,  0,  0, 0, 0,  1); // err is one pulse
        vecs[10] = mk(0, 0, 0, 0, 1, 12'd3840,     1,  0,  0,  0, 0, 1,  1); // min 60 sec 0
        vecs[11] = mk(0, 0, 0, 0, 1, 12'd58,       58, 0,  0,  0, 0, 0,  1); // load 00:58
        vecs[12] = mk(1, 0, 0, 0, 0, 12'd0,        58, 0,  1,  0, 0, 0,  0); // resume
        vecs[13] = mk(0, 0, 0, 1, 0, 12'd0,        59, 0,  1,  0, 0, 0,  0); // 00:59
        vecs[14] = mk(0, 0, 1, 1, 0, 12'd0,        0,  0,  0,  0, 0, 0,  0); // clr beats tick
        vecs[15] = mk(0, 0, 0, 0, 0, 12'd0,        0,  0,  0,  0, 0, 0,  1); // IDLE, ready

        drive(0, 0, 0, 0, 0, 12'd0);
        rst = 1'b1;
        #1;
        chk("rst.load_ready_comb", 32'(bus.load_ready), 32'd0);
        step();
        step();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("idle.load_ready", 32'(bus.load_ready), 32'd1);

        // start, then 60 consecutive ticks
        drive(1, 0, 0, 0, 0, 12'd0);
        step();
        chk("start.running", 32'(bus.running), 32'd1);
        for (int k = 1; k <= 60; k++) begin
            drive(0, 0, 0, 1, 0, 12'd0);
            step();
            chk($sformatf("tick%0d.sec", k), 32'(bus.sec), (k == 60) ? 32'd0 : 32'(k));
            chk($sformatf("tick%0d.min", k), 32'(bus.min), (k == 60) ? 32'd1 : 32'd0);
            chk($sformatf("tick%0d.sec_wrap", k), 32'(bus.sec_wrap), (k == 60) ? 32'd1 : 32'd0);
            chk($sformatf("tick%0d.hr_wrap", k), 32'(bus.hr_wrap), 32'd0);
        end
        drive(0, 0, 0, 0, 0, 12'd0);
        step();
        chk_all("postwrap", 0, 1, 1, 0, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].start, vecs[i].stop, vecs[i].clr, vecs[i].tick, vecs[i].lv, vecs[i].lval);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].esec, vecs[i].emin, vecs[i].erun,
                    vecs[i].eswr, vecs[i].ehwr, vecs[i].eerr, vecs[i].erdy);
        end

        // reset in the middle of RUN discards the count and a pending load
        drive(1, 0, 0, 0, 0, 12'd0);
        step();
        drive(0, 0, 0, 1, 0, 12'd0);
        step();
        chk("midrun.sec", 32'(bus.sec), 32'd1);
        rst = 1'b1;
        drive(0, 0, 0, 1, 1, 12'd100);
        step();
        chk_all("midrun_rst", 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_idle.load_ready_comb", 32'(bus.load_ready), 32'd0);
        step();
        chk("rst_idle.sec", 32'(bus.sec), 32'd0);
        chk("rst_idle.min", 32'(bus.min), 32'd0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 12'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mod60_ctrl
`default_nettype wire
